// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared definitions for the memory-access stage.
//   - MEMOP codes for loads and stores (unlisted codes behave as NONE)
//   - access-size encoding and is_load / is_store / size / signedness helpers
//   - stage state encoding
package mem_lsu_pkg;

  typedef enum logic [3:0] {
    MEMOP_NONE = 4'd0,
    MEMOP_LB   = 4'd1,
    MEMOP_LBU  = 4'd2,
    MEMOP_LH   = 4'd3,
    MEMOP_LHU  = 4'd4,
    MEMOP_LW   = 4'd5,
    MEMOP_SB   = 4'd6,
    MEMOP_SH   = 4'd7,
    MEMOP_SW   = 4'd8
  } memop_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic logic is_load(input logic [3:0] op);
    case (op)
      MEMOP_LB, MEMOP_LBU, MEMOP_LH, MEMOP_LHU, MEMOP_LW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    case (op)
      MEMOP_SB, MEMOP_SH, MEMOP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] mem_size(input logic [3:0] op);
    case (op)
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: return SZ_H;
      MEMOP_LW, MEMOP_SW:            return SZ_W;
      default:                       return SZ_B;
    endcase
  endfunction

  // Loads that sign-extend their result
  function automatic logic ld_signed(input logic [3:0] op);
    case (op)
      MEMOP_LB, MEMOP_LH, MEMOP_LW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane logic, big-endian lane order.
//   op / lane / sdata      -> sel (byte enables), st_data (replicated), misalign
//   ld_op / ld_lane / rdata -> ldata (extracted and extended load result)
// Lane k occupies bits [DATA_W-1-8k -: 8], so its enable bit is sel[NB-1-k].
module mem_lane_align
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB = DATA_W / 8,
  localparam int LB = $clog2(NB)
) (
  input  logic [3:0]        op,
  input  logic [LB-1:0]     lane,
  input  logic [DATA_W-1:0] sdata,
  input  logic [3:0]        ld_op,
  input  logic [LB-1:0]     ld_lane,
  input  logic [DATA_W-1:0] rdata,
  output logic [NB-1:0]     sel,
  output logic [DATA_W-1:0] st_data,
  output logic              misalign,
  output logic [DATA_W-1:0] ldata
);

  // Enable patterns for an access starting at lane 0; shifting right by the
  // lane index moves them down to the addressed lanes.
  localparam logic [NB-1:0] BYTE_MASK = ~({NB{1'b1}} >> 1);
  localparam logic [NB-1:0] HALF_MASK = ~({NB{1'b1}} >> 2);
  localparam logic [NB-1:0] WORD_MASK = ~({NB{1'b1}} >> 4);

  logic [DATA_W-1:0] shifted;
  logic              sgn;

  assign shifted = rdata << {ld_lane, 3'b000};
  assign sgn     = ld_signed(ld_op);

  always_comb begin
    sel      = '0;
    st_data  = '0;
    misalign = 1'b0;
    if (is_load(op) || is_store(op)) begin
      case (mem_size(op))
        SZ_H: begin
          sel      = HALF_MASK >> lane;
          misalign = lane[0];
          st_data  = {(NB/2){sdata[15:0]}};
        end
        SZ_W: begin
          sel      = WORD_MASK >> lane;
          misalign = (lane[1:0] != 2'b00);
          st_data  = {(NB/4){sdata[31:0]}};
        end
        default: begin
          sel      = BYTE_MASK >> lane;
          st_data  = {NB{sdata[7:0]}};
        end
      endcase
      if (!is_store(op)) st_data = '0;
    end
  end

  // Addressed bytes sit at the top of 'shifted'; fill with sign or zero first,
  // then overwrite the low bits with the extracted value.
  always_comb begin
    ldata = '0;
    case (mem_size(ld_op))
      SZ_H: begin
        ldata       = {DATA_W{sgn & shifted[DATA_W-1]}};
        ldata[15:0] = shifted[DATA_W-1 -: 16];
      end
      SZ_W: begin
        ldata       = {DATA_W{sgn & shifted[DATA_W-1]}};
        ldata[31:0] = shifted[DATA_W-1 -: 32];
      end
      default: begin
        ldata      = {DATA_W{sgn & shifted[DATA_W-1]}};
        ldata[7:0] = shifted[DATA_W-1 -: 8];
      end
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM pipeline stage with a req/ack data-memory port.
//   Upstream : valid_i, flush_i, memop_i, wd_i, wreg_i, wdata_i, addr_i, sdata_i
//   Memory   : mem_req_o, mem_we_o, mem_addr_o, mem_sel_o, mem_wdata_o,
//              mem_rdata_i, mem_ack_i
//   Pipeline : stall_req_o (combinational), wd_o / wreg_o / wdata_o (MEM/WB)
//   Faults   : excp_align_o, excp_bus_o (one-cycle pulses)
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MAX_WAIT   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic                  flush_i,
  input  logic [3:0]            memop_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     sdata_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W/8-1:0]   mem_sel_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic                  stall_req_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic                  excp_align_o,
  output logic                  excp_bus_o
);

  localparam int NB    = DATA_W / 8;
  localparam int LB    = $clog2(NB);
  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  state_e                state;
  logic [CNT_W-1:0]      cnt;
  logic [3:0]            op_q;
  logic [LB-1:0]         lane_q;
  logic [REG_ADDR_W-1:0] wd_q;
  logic                  wreg_q;
  logic                  flush_q;

  logic [NB-1:0]     sel;
  logic [DATA_W-1:0] st_data;
  logic              misalign;
  logic [DATA_W-1:0] ldata;
  logic              is_mem;
  logic              accept;
  logic              timeout;
  logic              killed;

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .op       (memop_i),
    .lane     (addr_i[LB-1:0]),
    .sdata    (sdata_i),
    .ld_op    (op_q),
    .ld_lane  (lane_q),
    .rdata    (mem_rdata_i),
    .sel      (sel),
    .st_data  (st_data),
    .misalign (misalign),
    .ldata    (ldata)
  );

  assign is_mem  = is_load(memop_i) | is_store(memop_i);
  assign accept  = (state == ST_IDLE) & valid_i & ~flush_i & is_mem & ~misalign;
  assign timeout = (state == ST_BUSY) & ~mem_ack_i & (cnt == CNT_LAST);
  // A flush in the completing cycle counts as well as an earlier sticky one
  assign killed  = flush_q | flush_i;

  always_comb begin
    if (state == ST_BUSY) stall_req_o = ~mem_ack_i;
    else                  stall_req_o = accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      op_q         <= 4'd0;
      lane_q       <= '0;
      wd_q         <= '0;
      wreg_q       <= 1'b0;
      flush_q      <= 1'b0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_sel_o    <= '0;
      mem_wdata_o  <= '0;
      wd_o         <= '0;
      wreg_o       <= 1'b0;
      wdata_o      <= '0;
      excp_align_o <= 1'b0;
      excp_bus_o   <= 1'b0;
    end else begin
      excp_align_o <= 1'b0;
      excp_bus_o   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (valid_i && !flush_i) begin
            if (!is_mem) begin
              wd_o    <= wd_i;
              wreg_o  <= wreg_i;
              wdata_o <= wdata_i;
            end else if (misalign) begin
              wreg_o       <= 1'b0;
              excp_align_o <= 1'b1;
            end else begin
              mem_req_o   <= 1'b1;
              mem_we_o    <= is_store(memop_i);
              mem_addr_o  <= {addr_i[ADDR_W-1:LB], {LB{1'b0}}};
              mem_sel_o   <= sel;
              mem_wdata_o <= st_data;
              op_q        <= memop_i;
              lane_q      <= addr_i[LB-1:0];
              wd_q        <= wd_i;
              wreg_q      <= wreg_i;
              flush_q     <= 1'b0;
              cnt         <= '0;
              wreg_o      <= 1'b0;
              state       <= ST_BUSY;
            end
          end else begin
            wreg_o <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            wd_o      <= wd_q;
            wreg_o    <= wreg_q & is_load(op_q) & ~killed;
            if (is_load(op_q)) wdata_o <= ldata;
            state     <= ST_IDLE;
          end else if (timeout) begin
            mem_req_o  <= 1'b0;
            wreg_o     <= 1'b0;
            excp_bus_o <= ~killed;
            state      <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (flush_i) flush_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed self-checking bench for mem_lsu (32-bit, MAX_WAIT=16).
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, flush_i, wreg_i, mem_ack_i;
  logic [3:0]  memop_i;
  logic [4:0]  wd_i;
  logic [31:0] wdata_i, addr_i, sdata_i, mem_rdata_i;
  logic        mem_req_o, mem_we_o, stall_req_o, wreg_o, excp_align_o, excp_bus_o;
  logic [31:0] mem_addr_o, mem_wdata_o, wdata_o;
  logic [3:0]  mem_sel_o;
  logic [4:0]  wd_o;

  int n_checks = 0;
  int n_fail   = 0;

  // values captured during run_access
  int          stalls;
  logic        cap_req, cap_we;
  logic [3:0]  cap_sel;
  logic [31:0] cap_addr, cap_wdata;

  mem_lsu #(.DATA_W(32), .ADDR_W(32), .REG_ADDR_W(5), .MAX_WAIT(16)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i), .memop_i(memop_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .addr_i(addr_i), .sdata_i(sdata_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_sel_o(mem_sel_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .mem_ack_i(mem_ack_i), .stall_req_o(stall_req_o), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .excp_align_o(excp_align_o), .excp_bus_o(excp_bus_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one aligned memory op, ack after 'delay' ack-less BUSY cycles,
  // optionally pulsing flush_i in the first BUSY cycle.
  task automatic run_access(input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] sd, input logic [31:0] rd,
                            input int delay, input bit flush_mid);
    valid_i = 1'b1; memop_i = op; addr_i = addr; sdata_i = sd; mem_rdata_i = rd;
    wd_i = 5'd7; wreg_i = 1'b1; mem_ack_i = 1'b0; flush_i = 1'b0;
    stalls = 0;
    #1;
    if (stall_req_o) stalls++;
    tick();
    cap_req = mem_req_o; cap_we = mem_we_o; cap_sel = mem_sel_o;
    cap_addr = mem_addr_o; cap_wdata = mem_wdata_o;
    for (int i = 0; i < delay; i++) begin
      flush_i = (flush_mid && i == 0);
      #1;
      if (stall_req_o) stalls++;
      tick();
    end
    flush_i = 1'b0; mem_ack_i = 1'b1;
    #1;
    if (stall_req_o) stalls++;
    tick();
    mem_ack_i = 1'b0; valid_i = 1'b0; memop_i = 4'd0;
  endtask

  int req_cnt, bus_cnt;

  initial begin
    rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; wreg_i = 1'b0; mem_ack_i = 1'b0;
    memop_i = 4'd0; wd_i = 5'd0; wdata_i = 32'd0; addr_i = 32'd0; sdata_i = 32'd0;
    mem_rdata_i = 32'd0;
    tick(); tick();
    check("rst_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_wreg", {31'd0, wreg_o}, 32'd0);
    check("rst_wdata", wdata_o, 32'd0);
    check("rst_excp", {30'd0, excp_align_o, excp_bus_o}, 32'd0);
    check("rst_stall", {31'd0, stall_req_o}, 32'd0);
    rst = 1'b0;
    tick();

    // non-memory op
    valid_i = 1'b1; memop_i = 4'd0; wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'h1234;
    #1;
    check("alu_stall", {31'd0, stall_req_o}, 32'd0);
    tick();
    check("alu_wd", {27'd0, wd_o}, 32'd5);
    check("alu_wreg", {31'd0, wreg_o}, 32'd1);
    check("alu_wdata", wdata_o, 32'h1234);
    check("alu_req", {31'd0, mem_req_o}, 32'd0);
    valid_i = 1'b0;
    tick();
    check("idle_wreg", {31'd0, wreg_o}, 32'd0);

    // LB / LBU at 0x1001
    run_access(4'd1, 32'h1001, 32'd0, 32'h0080_0000, 3, 1'b0);
    check("lb_req", {31'd0, cap_req}, 32'd1);
    check("lb_sel", {28'd0, cap_sel}, 32'b0100);
    check("lb_addr", cap_addr, 32'h1000);
    check("lb_we", {31'd0, cap_we}, 32'd0);
    check("lb_stalls", stalls, 32'd4);
    check("lb_data", wdata_o, 32'hFFFF_FF80);
    check("lb_wreg", {31'd0, wreg_o}, 32'd1);
    check("lb_wd", {27'd0, wd_o}, 32'd7);
    check("lb_req_off", {31'd0, mem_req_o}, 32'd0);
    run_access(4'd2, 32'h1001, 32'd0, 32'h0080_0000, 3, 1'b0);
    check("lbu_data", wdata_o, 32'h0000_0080);

    // halfword and word loads
    run_access(4'd3, 32'h1002, 32'd0, 32'h1234_8001, 1, 1'b0);
    check("lh_sel", {28'd0, cap_sel}, 32'b0011);
    check("lh_data", wdata_o, 32'hFFFF_8001);
    run_access(4'd4, 32'h1002, 32'd0, 32'h1234_8001, 0, 1'b0);
    check("lhu_data", wdata_o, 32'h0000_8001);
    run_access(4'd5, 32'h4000, 32'd0, 32'hDEAD_BEEF, 0, 1'b0);
    check("lw_sel", {28'd0, cap_sel}, 32'b1111);
    check("lw_data", wdata_o, 32'hDEAD_BEEF);

    // stores
    run_access(4'd7, 32'h2002, 32'h0000_ABCD, 32'd0, 0, 1'b0);
    check("sh_we", {31'd0, cap_we}, 32'd1);
    check("sh_sel", {28'd0, cap_sel}, 32'b0011);
    check("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    check("sh_addr", cap_addr, 32'h2000);
    check("sh_wreg", {31'd0, wreg_o}, 32'd0);
    check("sh_stalls", stalls, 32'd1);
    run_access(4'd6, 32'h5003, 32'h1234_5678, 32'd0, 0, 1'b0);
    check("sb_sel", {28'd0, cap_sel}, 32'b0001);
    check("sb_wdata", cap_wdata, 32'h7878_7878);

    // misaligned LW 0x3001 and LH 0x3003
    for (int k = 0; k < 2; k++) begin
      valid_i = 1'b1; memop_i = (k == 0) ? 4'd5 : 4'd3;
      addr_i = (k == 0) ? 32'h3001 : 32'h3003; wreg_i = 1'b1;
      #1;
      check("mis_stall", {31'd0, stall_req_o}, 32'd0);
      tick();
      check("mis_req", {31'd0, mem_req_o}, 32'd0);
      check("mis_align", {31'd0, excp_align_o}, 32'd1);
      check("mis_wreg", {31'd0, wreg_o}, 32'd0);
      valid_i = 1'b0;
      tick();
      check("mis_pulse", {31'd0, excp_align_o}, 32'd0);
    end

    // flush in IDLE drops the op
    valid_i = 1'b1; flush_i = 1'b1; memop_i = 4'd5; addr_i = 32'h4000; wreg_i = 1'b1;
    #1;
    check("fli_stall", {31'd0, stall_req_o}, 32'd0);
    tick();
    check("fli_req", {31'd0, mem_req_o}, 32'd0);
    check("fli_wreg", {31'd0, wreg_o}, 32'd0);
    valid_i = 1'b0; flush_i = 1'b0;
    tick();

    // timeout: no ack
    valid_i = 1'b1; memop_i = 4'd5; addr_i = 32'h4000; wreg_i = 1'b1;
    tick();
    valid_i = 1'b0; memop_i = 4'd0;
    req_cnt = 0; bus_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (mem_req_o) req_cnt++;
      if (excp_bus_o) bus_cnt++;
      tick();
    end
    check("to_req_cycles", req_cnt, 32'd16);
    check("to_bus_pulses", bus_cnt, 32'd1);
    check("to_wreg", {31'd0, wreg_o}, 32'd0);

    // ack on the 16th BUSY cycle completes normally
    valid_i = 1'b1; memop_i = 4'd5; addr_i = 32'h4000; wreg_i = 1'b1;
    mem_rdata_i = 32'hCAFE_F00D;
    tick();
    valid_i = 1'b0; memop_i = 4'd0;
    for (int i = 0; i < 15; i++) tick();
    check("ack16_req", {31'd0, mem_req_o}, 32'd1);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    check("ack16_bus", {31'd0, excp_bus_o}, 32'd0);
    check("ack16_wreg", {31'd0, wreg_o}, 32'd1);
    check("ack16_data", wdata_o, 32'hCAFE_F00D);
    tick();
    check("ack16_bus2", {31'd0, excp_bus_o}, 32'd0);

    // flush during BUSY is sticky
    run_access(4'd5, 32'h4000, 32'd0, 32'h0BAD_F00D, 2, 1'b1);
    check("flb_wreg", {31'd0, wreg_o}, 32'd0);

    // reset mid-BUSY
    valid_i = 1'b1; memop_i = 4'd5; addr_i = 32'h4000; wreg_i = 1'b1;
    tick();
    check("rb_req_before", {31'd0, mem_req_o}, 32'd1);
    rst = 1'b1; valid_i = 1'b0; memop_i = 4'd0;
    tick();
    rst = 1'b0;
    check("rb_req", {31'd0, mem_req_o}, 32'd0);
    check("rb_wdata", wdata_o, 32'd0);
    check("rb_sel", {28'd0, mem_sel_o}, 32'd0);
    check("rb_addr", mem_addr_o, 32'd0);
    mem_ack_i = 1'b1;
    #1;
    check("rb_stall", {31'd0, stall_req_o}, 32'd0);
    tick();
    mem_ack_i = 1'b0;
    check("rb_idle_wreg", {31'd0, wreg_o}, 32'd0);
    check("rb_idle_req", {31'd0, mem_req_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
